// File: rtl/wb_queue_if.sv
// Register-write request handshake between the producer and the write-back queue.
interface wb_queue_if;
    logic        req_valid;
    logic [4:0]  req_addr;
    logic [31:0] req_data;
    logic        req_ready;

    modport master (output req_valid, req_addr, req_data, input req_ready);
    modport slave  (input req_valid, req_addr, req_data, output req_ready);
endinterface

// File: rtl/wb_queue.sv
// Write-back queue: buffers register writes in a circular FIFO, drains them into the
// register bank one per unstalled cycle, and forwards pending data to the read ports.
module wb_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    wb_queue_if.slave               req,
    input  logic                    stall,
    input  logic                    flush,
    output logic [4:0]              AW,
    output logic [31:0]             Datow,
    output logic                    Wen,
    input  logic [4:0]              AR1,
    input  logic [4:0]              AR2,
    input  logic [31:0]             Dato1,
    input  logic [31:0]             Dato2,
    output logic [31:0]             Rd1,
    output logic [31:0]             Rd2,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    empty,
    output logic                    full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [PW-1:0]   head, tail;
    logic [PW-1:0]   head_nxt, tail_nxt;
    logic [CW-1:0]   count_nxt;
    logic            push, wr, pop;

    // Status is derived from the registered count only, so a same-cycle drain never frees a slot.
    assign empty         = (count == CW'(0));
    assign full          = (count == CW'(DEPTH));
    assign req.req_ready = !full;

    assign push = req.req_valid && req.req_ready && !flush;
    assign wr   = push && (req.req_addr != 5'd0);
    assign pop  = Wen;

    assign Wen  = !empty && !stall && !flush;

    always_comb begin
        AW    = 5'd0;
        Datow = 32'd0;
        if (!empty) begin
            AW    = mem[head].addr;
            Datow = mem[head].data;
        end
    end

    // Pointer/count next-state; flush wins over both push and pop.
    always_comb begin
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count;
        if (flush) begin
            head_nxt  = '0;
            tail_nxt  = '0;
            count_nxt = '0;
        end else begin
            if (pop) head_nxt = head + PW'(1);
            if (wr)  tail_nxt = tail + PW'(1);
            count_nxt = count + CW'(wr) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head_nxt;
            tail  <= tail_nxt;
            count <= count_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr) begin
            mem[tail] <= '{addr: req.req_addr, data: req.req_data};
        end
    end

    // Scan oldest to youngest so the youngest matching pending entry wins.
    function automatic logic [31:0] fwd(input logic [4:0] ar, input logic [31:0] raw);
        logic [31:0]   r;
        logic [PW-1:0] idx;
        r = raw;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (mem[idx].addr == ar)) r = mem[idx].data;
        end
        if (ar == 5'd0) r = 32'd0;
        return r;
    endfunction

    always_comb begin
        Rd1 = fwd(AR1, Dato1);
        Rd2 = fwd(AR2, Dato2);
    end

endmodule

// File: tb/tb_wb_queue.sv
// Directed bench for wb_queue: drain order, full/stall, forwarding, null writes, flush, reset.
module tb_wb_queue;

    logic        clk;
    logic        rst_n;
    logic        stall, flush;
    logic [4:0]  AW, AR1, AR2;
    logic [31:0] Datow, Dato1, Dato2, Rd1, Rd2;
    logic        Wen, empty, full;
    logic [2:0]  count;
    int          n_checks;
    int          n_fail;

    wb_queue_if bus();

    wb_queue #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus),
        .stall (stall),
        .flush (flush),
        .AW    (AW),
        .Datow (Datow),
        .Wen   (Wen),
        .AR1   (AR1),
        .AR2   (AR2),
        .Dato1 (Dato1),
        .Dato2 (Dato2),
        .Rd1   (Rd1),
        .Rd2   (Rd2),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [31:0] d);
        bus.req_valid = v;
        bus.req_addr  = a;
        bus.req_data  = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got empty=%0d full=%0d want 1 0", empty, full); end
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0d want 1", bus.req_ready); end
        n_checks++; if (Wen !== 1'b0 || AW !== 5'd0 || Datow !== 32'd0) begin n_fail++; $display("FAIL reset_bank: got Wen=%0d AW=%0d Datow=%0d want 0 0 0", Wen, AW, Datow); end
        rst_n = 1'b1;
        tick();
        n_checks++; if (Wen !== 1'b0) begin n_fail++; $display("FAIL reset_release_wen: got %0d want 0", Wen); end
    endtask

    task automatic test_single();
        drive(1'b1, 5'd5, 32'd10);
        #1;
        n_checks++; if (Wen !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL single_pre: got Wen=%0d ready=%0d want 0 1", Wen, bus.req_ready); end
        tick();
        drive(1'b0, 5'd0, 32'd0);
        #1;
        n_checks++; if (Wen !== 1'b1 || AW !== 5'd5 || Datow !== 32'd10) begin n_fail++; $display("FAIL single_write: got Wen=%0d AW=%0d Datow=%0d want 1 5 10", Wen, AW, Datow); end
        tick();
        n_checks++; if (empty !== 1'b1 || Wen !== 1'b0 || AW !== 5'd0) begin n_fail++; $display("FAIL single_drained: got empty=%0d Wen=%0d AW=%0d want 1 0 0", empty, Wen, AW); end
    endtask

    task automatic test_full();
        logic [4:0]  exp_a [4];
        logic [31:0] exp_d [4];
        exp_a = '{5'd6, 5'd7, 5'd8, 5'd9};
        exp_d = '{32'd15, 32'd20, 32'd25, 32'd30};
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, exp_a[i], exp_d[i]);
            tick();
        end
        drive(1'b1, 5'd10, 32'd35);
        #1;
        n_checks++; if (full !== 1'b1 || bus.req_ready !== 1'b0 || count !== 3'd4) begin n_fail++; $display("FAIL full_flags: got full=%0d ready=%0d count=%0d want 1 0 4", full, bus.req_ready, count); end
        n_checks++; if (Wen !== 1'b0) begin n_fail++; $display("FAIL full_stalled_wen: got %0d want 0", Wen); end
        tick();
        drive(1'b0, 5'd0, 32'd0);
        #1;
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_fifth_rejected: got count=%0d want 4", count); end
        stall = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (Wen !== 1'b1 || AW !== exp_a[i] || Datow !== exp_d[i]) begin
                n_fail++;
                $display("FAIL full_drain%0d: got Wen=%0d AW=%0d Datow=%0d want 1 %0d %0d", i, Wen, AW, Datow, exp_a[i], exp_d[i]);
            end
            tick();
        end
        n_checks++; if (empty !== 1'b1 || Wen !== 1'b0) begin n_fail++; $display("FAIL full_after_drain: got empty=%0d Wen=%0d want 1 0", empty, Wen); end
    endtask

    task automatic test_forward();
        stall = 1'b1;
        drive(1'b1, 5'd12, 32'd1);
        tick();
        drive(1'b1, 5'd12, 32'd2);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        AR1 = 5'd12; Dato1 = 32'd45;
        AR2 = 5'd0;  Dato2 = 32'd50;
        #1;
        n_checks++; if (Rd1 !== 32'd2) begin n_fail++; $display("FAIL fwd_youngest: got Rd1=%0d want 2", Rd1); end
        n_checks++; if (Rd2 !== 32'd0) begin n_fail++; $display("FAIL fwd_r0: got Rd2=%0d want 0", Rd2); end
        AR2 = 5'd13;
        #1;
        n_checks++; if (Rd2 !== 32'd50) begin n_fail++; $display("FAIL fwd_miss: got Rd2=%0d want 50", Rd2); end
        drive(1'b1, 5'd13, 32'd77);
        #1;
        n_checks++; if (Rd2 !== 32'd50) begin n_fail++; $display("FAIL fwd_same_cycle_push: got Rd2=%0d want 50", Rd2); end
        tick();
        drive(1'b0, 5'd0, 32'd0);
        #1;
        n_checks++; if (Rd2 !== 32'd77 || count !== 3'd3) begin n_fail++; $display("FAIL fwd_new_entry: got Rd2=%0d count=%0d want 77 3", Rd2, count); end
        stall = 1'b0;
        #1;
        n_checks++; if (Wen !== 1'b1 || AW !== 5'd12 || Datow !== 32'd1 || Rd1 !== 32'd2) begin n_fail++; $display("FAIL fwd_drain0: got Wen=%0d AW=%0d Datow=%0d Rd1=%0d want 1 12 1 2", Wen, AW, Datow, Rd1); end
        tick();
        n_checks++; if (AW !== 5'd12 || Datow !== 32'd2 || Rd1 !== 32'd2) begin n_fail++; $display("FAIL fwd_drain1: got AW=%0d Datow=%0d Rd1=%0d want 12 2 2", AW, Datow, Rd1); end
        tick();
        n_checks++; if (AW !== 5'd13 || Rd1 !== 32'd45 || Rd2 !== 32'd77) begin n_fail++; $display("FAIL fwd_head_written: got AW=%0d Rd1=%0d Rd2=%0d want 13 45 77", AW, Rd1, Rd2); end
        tick();
        n_checks++; if (empty !== 1'b1 || Rd2 !== 32'd50) begin n_fail++; $display("FAIL fwd_empty: got empty=%0d Rd2=%0d want 1 50", empty, Rd2); end
        AR1 = 5'd0; AR2 = 5'd0;
    endtask

    task automatic test_zero_addr();
        drive(1'b1, 5'd0, 32'd99);
        #1;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL zero_ready: got %0d want 1", bus.req_ready); end
        tick();
        drive(1'b0, 5'd0, 32'd0);
        #1;
        n_checks++; if (count !== 3'd0 || Wen !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL zero_discard: got count=%0d Wen=%0d empty=%0d want 0 0 1", count, Wen, empty); end
        tick();
        n_checks++; if (Wen !== 1'b0) begin n_fail++; $display("FAIL zero_no_wen: got %0d want 0", Wen); end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 5'd3, 32'd33);
        tick();
        drive(1'b1, 5'd0, 32'd5);
        #1;
        n_checks++; if (count !== 3'd1 || Wen !== 1'b1 || AW !== 5'd3) begin n_fail++; $display("FAIL b2b_pending: got count=%0d Wen=%0d AW=%0d want 1 1 3", count, Wen, AW); end
        tick();
        drive(1'b0, 5'd0, 32'd0);
        #1;
        n_checks++; if (count !== 3'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL b2b_null_pop: got count=%0d empty=%0d want 0 1", count, empty); end
        drive(1'b1, 5'd4, 32'd44);
        tick();
        drive(1'b1, 5'd5, 32'd55);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        #1;
        n_checks++; if (count !== 3'd1 || AW !== 5'd5 || Datow !== 32'd55) begin n_fail++; $display("FAIL b2b_push_pop: got count=%0d AW=%0d Datow=%0d want 1 5 55", count, AW, Datow); end
        tick();
        n_checks++; if (empty !== 1'b1) begin n_fail++; $display("FAIL b2b_drained: got empty=%0d want 1", empty); end
    endtask

    task automatic test_flush();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(21 + i), 32'(i + 1));
            tick();
        end
        drive(1'b0, 5'd0, 32'd0);
        #1;
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL flush_pre_count: got %0d want 3", count); end
        flush = 1'b1;
        stall = 1'b0;
        drive(1'b1, 5'd20, 32'd200);
        #1;
        n_checks++; if (Wen !== 1'b0) begin n_fail++; $display("FAIL flush_wen: got %0d want 0", Wen); end
        tick();
        flush = 1'b0;
        drive(1'b0, 5'd0, 32'd0);
        #1;
        n_checks++; if (count !== 3'd0 || Wen !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL flush_cleared: got count=%0d Wen=%0d empty=%0d want 0 0 1", count, Wen, empty); end
        tick();
        n_checks++; if (count !== 3'd0 || Wen !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got count=%0d Wen=%0d want 0 0", count, Wen); end
    endtask

    task automatic test_reset_mid();
        stall = 1'b1;
        drive(1'b1, 5'd24, 32'd7);
        tick();
        drive(1'b1, 5'd25, 32'd8);
        tick();
        drive(1'b0, 5'd0, 32'd0);
        stall = 1'b0;
        #1;
        n_checks++; if (Wen !== 1'b1 || AW !== 5'd24) begin n_fail++; $display("FAIL rstmid_pre: got Wen=%0d AW=%0d want 1 24", Wen, AW); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++; if (Wen !== 1'b0 || AW !== 5'd0 || Datow !== 32'd0 || count !== 3'd0) begin n_fail++; $display("FAIL rstmid_async: got Wen=%0d AW=%0d Datow=%0d count=%0d want 0 0 0 0", Wen, AW, Datow, count); end
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if (Wen !== 1'b0) begin n_fail++; $display("FAIL rstmid_release: got Wen=%0d want 0", Wen); end
        tick();
        n_checks++; if (Wen !== 1'b0 || empty !== 1'b1) begin n_fail++; $display("FAIL rstmid_after: got Wen=%0d empty=%0d want 0 1", Wen, empty); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        AR1 = 5'd0; AR2 = 5'd0;
        Dato1 = 32'd0; Dato2 = 32'd0;
        drive(1'b0, 5'd0, 32'd0);
        test_reset();
        test_single();
        test_full();
        test_forward();
        test_zero_addr();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
